rr_arbiter_8: RTL and testbench

- Eight-requester round-robin arbiter that produces a registered 3-bit grant index plus a valid flag.
- Sits directly upstream of the 3-to-8 decoder (`decoder_d`): `grant_idx` drives the decoder's `in`, and the decoder's one-hot `out` becomes the per-requester grant strobes.
- Fairness comes from a rotating priority pointer.
- Grant hold time is bounded by a requester release, a request drop, or an optional timeout.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 26 ++
 rtl/rr_arbiter_8.sv | 120 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the rr_arbiter_8 block.
package arb_pkg;

    localparam int N_REQ            = 8;
    localparam int IDX_W            = 3;
    localparam int MAX_HOLD_DEFAULT = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr, modulo N_REQ.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    always_comb begin
        logic [IDX_W-1:0] w_idx;
        pick_any = 1'b0;
        pick_idx = '0;
        w_idx    = '0;
        // The index width equals log2(N_REQ), so the addition wraps modulo 8 for free.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = ptr + IDX_W'(i);
            if (!pick_any && req[w_idx]) begin
                pick_any = 1'b1;
                pick_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester round-robin arbiter with a registered grant index and valid flag.
// Define RR_ARB_TIMEOUT_EN to enable the hold counter and the forced-release timeout.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             timeout
);

    arb_state_t       r_state,       w_state_nxt;
    logic             r_grant_valid, w_grant_valid_nxt;
    logic [IDX_W-1:0] r_grant_idx,   w_grant_idx_nxt;
    logic [IDX_W-1:0] r_ptr,         w_ptr_nxt;
    logic             r_timeout,     w_timeout_nxt;

    logic [IDX_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_rel_normal;
    logic             w_rel_hold;

    rr_pick u_pick (
        .req      (req),
        .ptr      (r_ptr),
        .pick_idx (w_pick_idx),
        .pick_any (w_pick_any)
    );

    assign w_rel_normal = done | ~req[r_grant_idx];

`ifdef RR_ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;

    assign w_rel_hold = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        if (r_state == GRANT) begin
            if (w_rel_normal || w_rel_hold) begin
                w_hold_cnt_nxt = '0;
            end else if (r_hold_cnt != '1) begin
                w_hold_cnt_nxt = r_hold_cnt + 1'b1;
            end
        end else begin
            w_hold_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign w_rel_hold = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_valid_nxt = r_grant_valid;
        w_grant_idx_nxt   = r_grant_idx;
        w_ptr_nxt         = r_ptr;
        w_timeout_nxt     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt       = GRANT;
                    w_grant_valid_nxt = 1'b1;
                    w_grant_idx_nxt   = w_pick_idx;
                end
            end
            GRANT: begin
                if (w_rel_normal || w_rel_hold) begin
                    w_state_nxt       = IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_ptr_nxt         = r_grant_idx + 1'b1;
                    // A coinciding done or request drop counts as a normal release.
                    w_timeout_nxt     = w_rel_hold & ~w_rel_normal;
                end
            end
            default: begin
                w_state_nxt       = IDLE;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_ptr         <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_ptr         <= w_ptr_nxt;
            r_timeout     <= w_timeout_nxt;
        end
    end

    assign grant_valid = r_grant_valid;
    assign grant_idx   = r_grant_idx;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8; covers both the default and the RR_ARB_TIMEOUT_EN build.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic       timeout;

    int total;
    int bad;

    rr_arbiter_8 #(.MAX_HOLD(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic v, input logic [2:0] idx, input logic to);
        chk({tag, ".valid"},   {7'd0, grant_valid}, {7'd0, v});
        chk({tag, ".idx"},     {5'd0, grant_idx},   {5'd0, idx});
        chk({tag, ".timeout"}, {7'd0, timeout},     {7'd0, to});
    endtask

    // Entered in the first cycle of a grant; holds two cycles, releases with done, ends in the bubble.
    task automatic grant_cycle(input string tag, input logic [2:0] exp_idx);
        chk_state({tag, ".c1"}, 1'b1, exp_idx, 1'b0);
        step();
        chk_state({tag, ".c2"}, 1'b1, exp_idx, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_state({tag, ".bubble"}, 1'b0, exp_idx, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = 8'hFF;
        done  = 1'b0;

        // Reset with all requests high.
        step();
        step();
        chk_state("reset", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        step();

        // Full rotation with every requester active.
        for (int k = 0; k < 9; k++) begin
            grant_cycle("rot", 3'(k % 8));
            step();
        end
        for (int k = 1; k <= 5; k++) begin
            grant_cycle("rot2", 3'(k));
            if (k < 5) step();
        end

        // Wrap: ptr=6, only requesters 0 and 1 active.
        req = 8'b0000_0011;
        step();
        grant_cycle("wrap0", 3'd0);
        step();
        grant_cycle("wrap1", 3'd1);

        // done and request drop on the same edge, next requester waiting.
        req = 8'h08;
        step();
        chk_state("g3", 1'b1, 3'd3, 1'b0);
        step();
        done = 1'b1;
        req  = 8'h10;
        step();
        done = 1'b0;
        chk_state("g3.rel", 1'b0, 3'd3, 1'b0);
        step();
        chk_state("g4", 1'b1, 3'd4, 1'b0);
        req = 8'h00;
        step();
        chk_state("g4.drop", 1'b0, 3'd4, 1'b0);
        step();
        chk_state("idle.hold", 1'b0, 3'd4, 1'b0);

        // Long hold by a sole requester.
        req = 8'h04;
        step();
        chk_state("hold.c1", 1'b1, 3'd2, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            step();
            chk_state("hold.cN", 1'b1, 3'd2, 1'b0);
        end
        step();
`ifdef RR_ARB_TIMEOUT_EN
        chk_state("hold.timeout", 1'b0, 3'd2, 1'b1);
        step();
        chk_state("hold.regrant", 1'b1, 3'd2, 1'b0);
`else
        chk_state("hold.c17", 1'b1, 3'd2, 1'b0);
        step();
        chk_state("hold.c18", 1'b1, 3'd2, 1'b0);
`endif
        req = 8'h00;
        step();
        chk_state("hold.drop", 1'b0, 3'd2, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
        // done on the last allowed cycle wins over the timeout.
        req = 8'h04;
        step();
        for (int k = 2; k <= 16; k++) step();
        chk_state("coinc.c16", 1'b1, 3'd2, 1'b0);
        done = 1'b1;
        step();
        done = 1'b0;
        chk_state("coinc.rel", 1'b0, 3'd2, 1'b0);
        req = 8'h00;
        step();
`endif

        // Reset in the middle of a grant of idx 6 (ptr is 3 at this point).
        req = 8'h40;
        step();
        chk_state("mid.g6", 1'b1, 3'd6, 1'b0);
        for (int k = 0; k < 5; k++) step();
        rst_n = 1'b0;
        step();
        chk_state("mid.reset", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b1;
        req   = 8'h09;
        step();
        chk_state("ptr0", 1'b1, 3'd0, 1'b0);
        req = 8'h00;
        step();
        chk_state("ptr0.rel", 1'b0, 3'd0, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req   = 8'hC0;
        step();
        chk_state("c0", 1'b1, 3'd6, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
